// File: rtl/pipe_ifid_skid_if.sv
// pipe_ifid_skid_if
//   Bundles the IF -> ID handshake, payload and status signals of the
//   IF/ID skid stage.
//   slave  : the stage itself (consumes IF entry + ID ready, drives the rest)
//   master : the surrounding pipeline (drives IF entry, flush, ID ready)
//
//   Handshake: an entry moves across a side on a rising clock edge exactly
//   when valid and ready are both high at that edge. A producer holding
//   valid high keeps its payload stable until the transfer happens. The
//   stage's ready is never a function of the consumer's ready.
interface pipe_ifid_skid_if #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 16,
    parameter int CNT_W   = 8
);
    logic               flush_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [PC_W-1:0]    pc_i;
    logic [INSTR_W-1:0] instr_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [PC_W-1:0]    pc_o;
    logic [INSTR_W-1:0] instr_o;
    logic               bubble_o;
    logic [1:0]         occ_o;
    logic [CNT_W-1:0]   drop_cnt_o;

    modport slave (
        input  flush_i, in_valid_i, pc_i, instr_i, out_ready_i,
        output in_ready_o, out_valid_o, pc_o, instr_o, bubble_o, occ_o,
        output drop_cnt_o
    );

    modport master (
        output flush_i, in_valid_i, pc_i, instr_i, out_ready_i,
        input  in_ready_o, out_valid_o, pc_o, instr_o, bubble_o, occ_o,
        input  drop_cnt_o
    );
endinterface

// File: rtl/pipe_ifid_skid.sv
// pipe_ifid_skid
//   Two-entry IF/ID pipeline register with a skid slot. The main register
//   drives the ID side; the skid register catches one extra entry when ID
//   stalls, so in_ready_o depends only on the stage's own state.
//   A flush either empties the stage (FLUSH_MODE 0) or replaces its contents
//   with a single bubble (FLUSH_MODE 1), and counts discarded valid entries
//   in a saturating counter.
// Ports:
//   clk_i  : clock, all state changes on rising edge
//   rst_i  : synchronous active-high reset
//   bus    : pipe_ifid_skid_if.slave (IF entry in, ID entry out, flush,
//            bubble flag, occupancy = FSM state, drop counter)
module pipe_ifid_skid #(
    parameter int                 PC_W       = 16,
    parameter int                 INSTR_W    = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR  = INSTR_W'(16'h0003),
    parameter bit                 FLUSH_MODE = 1'b1,
    parameter int                 CNT_W      = 8
) (
    input logic               clk_i,
    input logic               rst_i,
    pipe_ifid_skid_if.slave   bus
);
    // Encoding equals the number of held entries, so occ_o is the state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state, state_n;
    logic [PC_W-1:0]    main_pc, main_pc_n, skid_pc, skid_pc_n;
    logic [INSTR_W-1:0] main_instr, main_instr_n, skid_instr, skid_instr_n;
    logic               main_bub, main_bub_n;
    logic [CNT_W-1:0]   drop_cnt, drop_cnt_n;

    logic               in_ready, accept, fire;
    logic [2:0]         n_drop;
    logic [CNT_W+1:0]   drop_sum;

    assign in_ready = (state != FULL) && !rst_i;
    assign accept   = bus.in_valid_i && in_ready;
    assign fire     = (state != EMPTY) && bus.out_ready_i;

    // Entries lost to a flush: everything held that does not leave to ID
    // this cycle, plus whatever IF hands over in the same cycle.
    assign n_drop   = {1'b0, state} - {2'b00, fire} + {2'b00, accept};
    assign drop_sum = (CNT_W+2)'(drop_cnt) + (CNT_W+2)'(n_drop);

    always_comb begin
        state_n      = state;
        main_pc_n    = main_pc;
        main_instr_n = main_instr;
        main_bub_n   = main_bub;
        skid_pc_n    = skid_pc;
        skid_instr_n = skid_instr;
        drop_cnt_n   = drop_cnt;

        if (bus.flush_i) begin
            drop_cnt_n = (drop_sum > (CNT_W+2)'(CNT_MAX)) ? CNT_MAX
                                                          : drop_sum[CNT_W-1:0];
            if (FLUSH_MODE) begin
                state_n      = ONE;
                main_pc_n    = '0;
                main_instr_n = NOP_INSTR;
                main_bub_n   = 1'b1;
            end else begin
                state_n = EMPTY;
            end
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state_n      = ONE;
                        main_pc_n    = bus.pc_i;
                        main_instr_n = bus.instr_i;
                        main_bub_n   = 1'b0;
                    end
                end
                ONE: begin
                    if (accept && fire) begin
                        main_pc_n    = bus.pc_i;
                        main_instr_n = bus.instr_i;
                        main_bub_n   = 1'b0;
                    end else if (accept) begin
                        state_n      = FULL;
                        skid_pc_n    = bus.pc_i;
                        skid_instr_n = bus.instr_i;
                    end else if (fire) begin
                        state_n = EMPTY;
                    end
                end
                FULL: begin
                    // Skid entries always come from IF, never a bubble.
                    if (fire) begin
                        state_n      = ONE;
                        main_pc_n    = skid_pc;
                        main_instr_n = skid_instr;
                        main_bub_n   = 1'b0;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= EMPTY;
            main_pc    <= '0;
            main_instr <= NOP_INSTR;
            main_bub   <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= NOP_INSTR;
            drop_cnt   <= '0;
        end else begin
            state      <= state_n;
            main_pc    <= main_pc_n;
            main_instr <= main_instr_n;
            main_bub   <= main_bub_n;
            skid_pc    <= skid_pc_n;
            skid_instr <= skid_instr_n;
            drop_cnt   <= drop_cnt_n;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = (state != EMPTY);
    assign bus.pc_o        = main_pc;
    assign bus.instr_o     = main_instr;
    assign bus.bubble_o    = main_bub;
    assign bus.occ_o       = state;
    assign bus.drop_cnt_o  = drop_cnt;
endmodule

// File: tb/tb_pipe_ifid_skid.sv
// tb_pipe_ifid_skid
//   Drives three configurations of pipe_ifid_skid with one shared stimulus:
//   k=0 FLUSH_MODE 1 / CNT_W 8, k=1 FLUSH_MODE 0 / CNT_W 8,
//   k=2 FLUSH_MODE 1 / CNT_W 2. Each is compared with a queue-based model.
module tb_pipe_ifid_skid;
    localparam logic [15:0] NOP = 16'h0003;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
        logic        bub;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [15:0] pc, instr;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    ent_t mq [3][$];
    int   mdrop [3];
    bit   mrst  [3];
    int   mmode [3] = '{1, 0, 1};
    int   mmax  [3] = '{255, 255, 3};

    always #5 clk = ~clk;

    pipe_ifid_skid_if #(.PC_W(16), .INSTR_W(16), .CNT_W(8)) bus0 ();
    pipe_ifid_skid_if #(.PC_W(16), .INSTR_W(16), .CNT_W(8)) bus1 ();
    pipe_ifid_skid_if #(.PC_W(16), .INSTR_W(16), .CNT_W(2)) bus2 ();

    assign bus0.flush_i = flush;  assign bus0.in_valid_i = in_valid;
    assign bus0.pc_i = pc;        assign bus0.instr_i = instr;
    assign bus0.out_ready_i = out_ready;
    assign bus1.flush_i = flush;  assign bus1.in_valid_i = in_valid;
    assign bus1.pc_i = pc;        assign bus1.instr_i = instr;
    assign bus1.out_ready_i = out_ready;
    assign bus2.flush_i = flush;  assign bus2.in_valid_i = in_valid;
    assign bus2.pc_i = pc;        assign bus2.instr_i = instr;
    assign bus2.out_ready_i = out_ready;

    pipe_ifid_skid #(.FLUSH_MODE(1'b1), .CNT_W(8)) dut0 (
        .clk_i(clk), .rst_i(rst), .bus(bus0));
    pipe_ifid_skid #(.FLUSH_MODE(1'b0), .CNT_W(8)) dut1 (
        .clk_i(clk), .rst_i(rst), .bus(bus1));
    pipe_ifid_skid #(.FLUSH_MODE(1'b1), .CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .bus(bus2));

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input int k, input logic v, input logic [1:0] occ,
                              input logic [15:0] p, input logic [15:0] ins,
                              input logic bub, input logic [7:0] drop);
        string s;
        s = $sformatf("k%0d", k);
        chk({s, "_out_valid"}, 32'(v), 32'(mq[k].size() > 0));
        chk({s, "_occ"}, 32'(occ), 32'(mq[k].size()));
        chk({s, "_drop_cnt"}, 32'(drop), 32'(mdrop[k]));
        if (mq[k].size() > 0) begin
            chk({s, "_pc"}, 32'(p), 32'(mq[k][0].pc));
            chk({s, "_instr"}, 32'(ins), 32'(mq[k][0].instr));
            chk({s, "_bubble"}, 32'(bub), 32'(mq[k][0].bub));
        end
        if (mrst[k]) begin
            chk({s, "_rst_pc"}, 32'(p), 32'h0);
            chk({s, "_rst_instr"}, 32'(ins), 32'(NOP));
            chk({s, "_rst_bubble"}, 32'(bub), 32'h0);
        end
    endtask

    // Reference behaviour: the stage is an ordered list of at most two entries.
    task automatic model_update(input int k);
        int   sz, acc, fir, d;
        ent_t e;
        sz  = mq[k].size();
        acc = (in_valid && sz < 2) ? 1 : 0;
        fir = (out_ready && sz > 0) ? 1 : 0;
        if (rst) begin
            mq[k].delete();
            mdrop[k] = 0;
            mrst[k]  = 1'b1;
        end else begin
            mrst[k] = 1'b0;
            if (flush) begin
                d = sz - fir + acc;
                mdrop[k] = (mdrop[k] + d > mmax[k]) ? mmax[k] : mdrop[k] + d;
                mq[k].delete();
                if (mmode[k] == 1) begin
                    e = '{pc: 16'h0, instr: NOP, bub: 1'b1};
                    mq[k].push_back(e);
                end
            end else begin
                if (fir == 1) void'(mq[k].pop_front());
                if (acc == 1) begin
                    e = '{pc: pc, instr: instr, bub: 1'b0};
                    mq[k].push_back(e);
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [15:0] p, input logic [15:0] ins,
                        input logic ordy);
        @(negedge clk);
        if (chk_en) begin
            check_outs(0, bus0.out_valid_o, bus0.occ_o, bus0.pc_o, bus0.instr_o,
                       bus0.bubble_o, bus0.drop_cnt_o);
            check_outs(1, bus1.out_valid_o, bus1.occ_o, bus1.pc_o, bus1.instr_o,
                       bus1.bubble_o, bus1.drop_cnt_o);
            check_outs(2, bus2.out_valid_o, bus2.occ_o, bus2.pc_o, bus2.instr_o,
                       bus2.bubble_o, {6'b0, bus2.drop_cnt_o});
        end
        rst = r; flush = f; in_valid = iv; pc = p; instr = ins; out_ready = ordy;
        #1;
        if (chk_en) begin
            chk("k0_in_ready", 32'(bus0.in_ready_o), 32'(!r && mq[0].size() < 2));
            chk("k1_in_ready", 32'(bus1.in_ready_o), 32'(!r && mq[1].size() < 2));
            chk("k2_in_ready", 32'(bus2.in_ready_o), 32'(!r && mq[2].size() < 2));
        end
        for (int k = 0; k < 3; k++) model_update(k);
        chk_en = 1'b1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        pc = '0; instr = '0;

        // reset
        step(1, 0, 0, 16'h0, 16'h0, 0);
        step(1, 1, 1, 16'h9, 16'h9, 1);

        // streaming
        for (int i = 1; i <= 5; i++) step(0, 0, 1, 16'(i), 16'(i + 100), 1);
        step(0, 0, 0, 16'h0, 16'h0, 1);

        // backpressure: 5 and 6 held, 7 refused, then drained in order
        step(0, 0, 1, 16'h5, 16'h105, 0);
        step(0, 0, 1, 16'h6, 16'h106, 0);
        step(0, 0, 1, 16'h7, 16'h107, 0);
        step(0, 0, 1, 16'h7, 16'h107, 1);
        step(0, 0, 0, 16'h0, 16'h0, 1);
        step(0, 0, 0, 16'h0, 16'h0, 1);
        step(0, 0, 0, 16'h0, 16'h0, 1);

        // flush while FULL, ID stalled, IF offering
        step(0, 0, 1, 16'h10, 16'h110, 0);
        step(0, 0, 1, 16'h11, 16'h111, 0);
        step(0, 1, 1, 16'h12, 16'h112, 0);
        @(posedge clk); #1;
        chk("flush_full_occ", 32'(bus0.occ_o), 32'd1);
        chk("flush_full_instr", 32'(bus0.instr_o), 32'h0003);
        chk("flush_full_pc", 32'(bus0.pc_o), 32'h0);
        chk("flush_full_bubble", 32'(bus0.bubble_o), 32'h1);
        chk("flush_full_drop", 32'(bus0.drop_cnt_o), 32'd2);

        // repeated flushes while FULL on the 2-bit counter
        step(0, 0, 1, 16'h13, 16'h113, 0);
        step(0, 1, 0, 16'h0, 16'h0, 0);
        @(posedge clk); #1;
        chk("sat_drop_3", 32'(bus2.drop_cnt_o), 32'd3);
        step(0, 0, 1, 16'h14, 16'h114, 0);
        step(0, 1, 0, 16'h0, 16'h0, 0);
        @(posedge clk); #1;
        chk("sat_drop_hold", 32'(bus2.drop_cnt_o), 32'd3);

        // flush in mode 0 while ONE with fire and accept in the same cycle
        step(0, 0, 1, 16'h20, 16'h120, 0);
        step(0, 1, 1, 16'h21, 16'h121, 1);
        @(posedge clk); #1;
        chk("m0_flush_occ", 32'(bus1.occ_o), 32'd0);
        chk("m0_flush_valid", 32'(bus1.out_valid_o), 32'd0);

        // reset while FULL with flush asserted
        step(0, 0, 1, 16'h30, 16'h130, 0);
        step(0, 0, 1, 16'h31, 16'h131, 0);
        step(1, 1, 1, 16'h32, 16'h132, 0);
        @(posedge clk); #1;
        chk("rst_full_occ", 32'(bus0.occ_o), 32'd0);
        chk("rst_full_valid", 32'(bus0.out_valid_o), 32'd0);
        chk("rst_full_drop", 32'(bus0.drop_cnt_o), 32'd0);
        chk("rst_full_instr", 32'(bus0.instr_o), 32'(NOP));

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0),
                 16'($urandom), 16'($urandom),
                 ($urandom_range(0, 1) == 1));
        end
        step(0, 0, 0, 16'h0, 16'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
